// File: rtl/demux_deser.sv
// rtl/demux_deser.sv - bit-serial to word-parallel deserializer (define DEMUX_ADDR_EN for addressed bit writes)
module demux_deser #(
    parameter int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
`ifdef DEMUX_ADDR_EN
    input  logic [W-1:0] in_sel,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_word,
    output logic [W:0]   bit_cnt
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] word_d;
    logic [W:0]   cnt_d;
    logic         accept;

    assign in_ready  = !rst && (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

`ifdef DEMUX_ADDR_EN
    logic [N-1:0] written_q, written_d;
    logic         sel_ok;

    // Out-of-range selects only exist when N is not a power of two.
    if ((1 << W) == N) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (int'(in_sel) < N);
    end

    function automatic logic [W:0] popcount(input logic [N-1:0] m);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + (W+1)'(m[i]);
        return c;
    endfunction
`else
    logic [W-1:0] idx_q, idx_d;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = out_word;
        cnt_d   = bit_cnt;
`ifdef DEMUX_ADDR_EN
        written_d = written_q;
`else
        idx_d = idx_q;
`endif
        case (state_q)
            COLLECT: begin
                if (accept) begin
`ifdef DEMUX_ADDR_EN
                    if (sel_ok) begin
                        word_d[in_sel]    = in_bit;
                        written_d[in_sel] = 1'b1;
                        cnt_d             = popcount(written_d);
                        if (&written_d) state_d = HOLD;
                    end
`else
                    word_d[idx_q] = in_bit;
                    cnt_d         = bit_cnt + (W+1)'(1);
                    idx_d         = idx_q + W'(1);
                    if (bit_cnt == (W+1)'(N-1)) state_d = HOLD;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    word_d  = '0;
                    cnt_d   = '0;
`ifdef DEMUX_ADDR_EN
                    written_d = '0;
`else
                    idx_d = '0;
`endif
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            out_word <= '0;
            bit_cnt  <= '0;
`ifdef DEMUX_ADDR_EN
            written_q <= '0;
`else
            idx_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            out_word <= word_d;
            bit_cnt  <= cnt_d;
`ifdef DEMUX_ADDR_EN
            written_q <= written_d;
`else
            idx_q <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_demux_deser.sv
// tb/tb_demux_deser.sv - directed self-checking bench for demux_deser
module tb_demux_deser;
`ifdef DEMUX_ADDR_EN
    localparam int N = 32;
`else
    localparam int N = 8;
`endif
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_bit = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_word;
    logic [W:0]   bit_cnt;
`ifdef DEMUX_ADDR_EN
    logic [W-1:0] in_sel = '0;
`endif

    int n_pass = 0;
    int n_total = 0;

    demux_deser #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
`ifdef DEMUX_ADDR_EN
        .in_sel    (in_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifndef DEMUX_ADDR_EN
    task automatic send_word(input logic [N-1:0] w, input string tag);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_bit   = w[k];
            check({tag, "_rdy"}, 64'(in_ready), 64'd1);
            tick();
            check({tag, "_cnt"}, 64'(bit_cnt), 64'(k + 1));
            check({tag, "_vld"}, 64'(out_valid), 64'(k == N - 1));
        end
        in_valid = 1'b0;
        check({tag, "_word"}, 64'(out_word), 64'(w));
    endtask
`endif

    initial begin
        tick();
        check("rst_rdy", 64'(in_ready), 64'd0);
        tick();
        check("rst_word", 64'(out_word), 64'd0);
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_cnt", 64'(bit_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 64'(in_ready), 64'd1);

`ifndef DEMUX_ADDR_EN
        // Sequential word held while the consumer stalls
        send_word(8'b0100_1101, "seq");
        check("seq_cnt_full", 64'(bit_cnt), 64'd8);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("seq_hold_rdy", 64'(in_ready), 64'd0);
            tick();
            check("seq_hold_word", 64'(out_word), 64'h4D);
            check("seq_hold_vld", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check("seq_rel_vld", 64'(out_valid), 64'd0);
        check("seq_rel_word", 64'(out_word), 64'd0);
        check("seq_rel_cnt", 64'(bit_cnt), 64'd0);
        check("seq_rel_rdy", 64'(in_ready), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check("seq_idle_cnt", 64'(bit_cnt), 64'd0);

        // Back-to-back words, period N+1 with out_ready held high
        out_ready = 1'b1;
        begin
            logic [N-1:0] words [3];
            words[0] = 8'hA5;
            words[1] = 8'h3C;
            words[2] = 8'hF0;
            for (int w = 0; w < 3; w++) begin
                send_word(words[w], "b2b");
                in_valid = 1'b1;
                in_bit   = (w < 2) ? words[(w + 1) % 3][0] : 1'b0;
                check("b2b_hold_rdy", 64'(in_ready), 64'd0);
                tick();
                check("b2b_one_cycle", 64'(out_valid), 64'd0);
                check("b2b_clr_word", 64'(out_word), 64'd0);
                check("b2b_clr_cnt", 64'(bit_cnt), 64'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Source stalls: in_valid toggles, bogus bits while invalid
        begin
            logic [N-1:0] sw;
            sw = 8'h96;
            for (int k = 0; k < N; k++) begin
                in_valid = 1'b0;
                in_bit   = ~sw[k];
                tick();
                check("stall_idle_cnt", 64'(bit_cnt), 64'(k));
                in_valid = 1'b1;
                in_bit   = sw[k];
                tick();
                check("stall_acc_cnt", 64'(bit_cnt), 64'(k + 1));
            end
            in_valid = 1'b0;
            check("stall_word", 64'(out_word), 64'h96);
            check("stall_vld", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check("stall_rel_vld", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Mid-word reset after 5 bits
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        check("mid_cnt5", 64'(bit_cnt), 64'd5);
        check("mid_word5", 64'(out_word), 64'h1F);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 64'(in_ready), 64'd0);
        tick();
        check("mid_word", 64'(out_word), 64'd0);
        check("mid_cnt", 64'(bit_cnt), 64'd0);
        check("mid_vld", 64'(out_valid), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_idle_vld", 64'(out_valid), 64'd0);
        send_word(8'h5A, "mid_next");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_next_rel", 64'(out_valid), 64'd0);
`else
        // Addressed one-hot walk, indices 31 down to 0
        for (int j = N - 1; j >= 0; j--) begin
            in_valid = 1'b1;
            in_sel   = W'(j);
            in_bit   = (j == 5);
            check("walk_vld_pre", 64'(out_valid), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        check("walk_word", 64'(out_word), 64'h0000_0020);
        check("walk_cnt", 64'(bit_cnt), 64'd32);
        check("walk_vld", 64'(out_valid), 64'd1);
        check("walk_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("walk_rel_vld", 64'(out_valid), 64'd0);
        check("walk_rel_cnt", 64'(bit_cnt), 64'd0);

        // Duplicate write to index 3 overwrites without counting
        in_valid = 1'b1;
        in_sel   = W'(3);
        in_bit   = 1'b1;
        tick();
        check("dup1_cnt", 64'(bit_cnt), 64'd1);
        check("dup1_word", 64'(out_word), 64'h8);
        in_bit = 1'b0;
        tick();
        check("dup2_cnt", 64'(bit_cnt), 64'd1);
        check("dup2_word", 64'(out_word), 64'h0);
        for (int j = 0; j < N; j++) begin
            if (j != 3) begin
                in_sel = W'(j);
                in_bit = 1'b1;
                tick();
                check("dup_fill_vld", 64'(out_valid), 64'(j == N - 1));
            end
        end
        in_valid = 1'b0;
        check("dup_word", 64'(out_word), 64'hFFFF_FFF7);
        check("dup_cnt", 64'(bit_cnt), 64'd32);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("dup_rel_word", 64'(out_word), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux_deser.md
# demux_deser

Bit-serial to word-parallel deserializer that writes each accepted input bit into one indexed position of an N-bit word register, acting as a demultiplexer over time. It is the receive end of the indexed-select mux path: a mux driven by a bit counter serializes a word LSB first, and this block rebuilds the word. It sits between a 1-bit valid/ready stream and a word-wide valid/ready consumer.

## Interface
- `N`, default 32: word width in bits; must be ≥ 2. `W = $clog2(N)`.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_bit` is valid this cycle.
- `in_ready`, output, 1: block can accept a bit this cycle.
- `in_bit`, input, 1: serial data bit.
- `in_sel`, input, W: target bit index. Present only with `DEMUX_ADDR_EN`.
- `out_valid`, output, 1: `out_word` holds a complete word.
- `out_ready`, input, 1: consumer accepts the word.
- `out_word`, output, N: assembled word, registered.
- `bit_cnt`, output, W+1: number of bits accepted into the current word, 0..N.

## Operation
- There are two states, `COLLECT` and `HOLD`. Reset state is `COLLECT`.
- Reset values: `out_word = 0`, `out_valid = 0`, `bit_cnt = 0`, internal index `idx = 0`.
- `in_ready = !rst && state == COLLECT`. It is combinational from state.
- `out_valid = (state == HOLD)`.
- A bit is accepted when `in_valid && in_ready`. The block then sets `out_word[idx] <= in_bit`, and `bit_cnt` increments.
- Default mode, without the macro:
  - `idx` starts at 0 and increments by 1 per accepted bit, so bit k of the stream goes to `out_word[k]` (LSB first).
  - On the N-th accepted bit (`bit_cnt == N-1` before the accept), go to `HOLD`. `bit_cnt` reads N in `HOLD`.
- In `HOLD`:
  - `out_word` is stable and no bits are accepted.
  - When `out_ready` is 1, go to `COLLECT`. In the same edge, clear `out_word`, `bit_cnt` and `idx` to 0.
- `in_valid` while `in_ready = 0` is ignored. The bit is not consumed, and the source must hold it.
- `out_ready` while in `COLLECT` is ignored.
- Reset mid-word: the partial word is discarded and all state returns to reset values on the next edge. No `out_valid` is produced for it.
- Unused `out_word` bits read 0 during `COLLECT`.

## Timing
- `in_ready` is 1 in the first cycle after `rst` deasserts.
- Accept rate is 1 bit per cycle in `COLLECT`.
- `out_valid` rises on the clock edge that accepts the final bit, so it is visible the cycle after that bit is presented.
- The `HOLD` to `COLLECT` transition uses the edge where `out_valid && out_ready`. `in_ready` is 1 the following cycle.
- There is no overlap between words. Minimum period per word is N + 1 cycles when `out_ready` is held at 1.
- All outputs except `in_ready` are registered.

## Configuration
- `DEMUX_ADDR_EN` defined (addressed mode):
  - The `in_sel` port exists, and an accepted bit is written to `out_word[in_sel]`.
  - An internal N-bit `written` mask sets bit `in_sel` on each accept.
  - `bit_cnt` is the popcount of `written`, so a rewrite of an already-written index overwrites the data and does not advance the count.
  - `in_sel ≥ N` (only possible when N is not a power of 2) is accepted and dropped: `in_ready` stays 1 and there is no write and no count.
  - Go to `HOLD` on the accept that makes `written` all-ones. The mask clears together with `out_word`.
- `DEMUX_ADDR_EN` not defined:
  - There is no `in_sel` port and no mask.
  - Behaviour is the sequential counter mode described above.

## Test plan
- **Sequential word:** N=8, stream bits 1,0,1,1,0,0,1,0 with `in_valid`=1 and `out_ready`=0.
  - `out_valid`=1 after the 8th bit, with `out_word`=8'b0100_1101 and `bit_cnt`=8.
  - `in_ready`=0 until `out_ready`=1.
- **Back-to-back:** N=8, 3 words with `out_ready`=1 throughout. Each word appears for exactly 1 cycle, the period is 9 cycles, and no bits are lost.
- **Source stalls:** N=8, `in_valid` toggles every cycle. The word is still correct, and `bit_cnt` advances only on accepts.
- **Mid-word reset:** N=8, pulse `rst` for 1 cycle after 5 bits.
  - Outputs return to 0 with no `out_valid`.
  - The next 8 bits form a correct word.
- **Addressed mode, one-hot walk (`DEMUX_ADDR_EN`):** N=32, write bit j = (j==5) at `in_sel`=j in order 31 down to 0. Expect `out_word`=32'h0000_0020.
- **Addressed mode, duplicate write (`DEMUX_ADDR_EN`):** N=32, write `in_sel`=3 twice (1, then 0). Expect `bit_cnt`=1 and `out_word[3]`=0, with `out_valid` only after all 32 indices are written.
